// File: rtl/cmd_sequencer.sv
// cmd_sequencer: strobed-command front-end FSM driving the converter
// precharge/ready/run/stop/discharge life-cycle.
module cmd_sequencer #(
  parameter int FREQ      = 50000,
  parameter int CHARGE_US = 100,
  parameter int DISCH_US  = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_strobe,
  input  logic [2:0] i_cmd,
  input  logic       i_stop_k,
  input  logic       i_fault,
  output logic       o_charge,
  output logic       o_ready,
  output logic       o_run,
  output logic [1:0] o_phase,
  output logic       o_stop,
  output logic       o_disch,
  output logic       o_fault,
  output logic       o_cmd_err
);
  localparam int CL = FREQ * CHARGE_US / 1000 - 1;
  localparam int DL = FREQ * DISCH_US / 1000 - 1;
  localparam int TW = $clog2(CL > DL ? CL : DL) + 1;
  localparam logic [TW-1:0] CLT = TW'(CL);
  localparam logic [TW-1:0] DLT = TW'(DL);

  typedef enum logic [2:0] {IDLE, CHARGE, READY, RUN, STOP, DISCH, FAULT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    str_q, cmd1_q, cmd2_q, trk_q, trk_d, trk_exp;
  logic [1:0]    stp_q, flt_q, phase_q, phase_d;
  logic [TW-1:0] t_q, t_d;
  logic          frm_q, frm_d;
  logic          cmd_vld, nz, err, acc, armed, sel, cmd5, cmd6, stop_s, flt_s, expired;
  logic          charge_d, ready_d, run_d, stop_d, disch_d, fault_d, err_d;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      str_q  <= '0;
      cmd1_q <= '0;
      cmd2_q <= '0;
      stp_q  <= '0;
      flt_q  <= '0;
    end else begin
      str_q  <= {str_q[1:0], i_strobe};
      cmd1_q <= i_cmd;
      cmd2_q <= cmd1_q;
      stp_q  <= {stp_q[0], i_stop_k};
      flt_q  <= {flt_q[0], i_fault};
    end

  assign cmd_vld = str_q[1] & ~str_q[2];
  assign stop_s  = stp_q[1];
  assign flt_s   = flt_q[1];
  assign nz      = |cmd2_q;
  assign err     = cmd_vld & nz & frm_q;
  assign acc     = cmd_vld & ~err;
  assign frm_d   = acc ? nz : frm_q;
  // arming sequence 7,0,7,0,1: even steps expect 7, odd steps expect 0, step 4 expects 1
  assign trk_exp = (trk_q == 3'd4) ? 3'd1 : trk_q[0] ? 3'd0 : 3'd7;
  assign armed   = acc & (trk_q == 3'd4) & (cmd2_q == 3'd1);
  assign trk_d   = !acc ? trk_q : armed ? 3'd0 : (cmd2_q == trk_exp) ? trk_q + 3'd1 :
                   (cmd2_q == 3'd7) ? 3'd1 : 3'd0;
  assign sel     = acc & ~armed & nz & (cmd2_q <= 3'd4);
  assign cmd5    = acc & (cmd2_q == 3'd5);
  assign cmd6    = acc & (cmd2_q == 3'd6);
  assign expired = t_q == '0;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q   <= IDLE;
      t_q       <= '0;
      frm_q     <= 1'b0;
      trk_q     <= '0;
      phase_q   <= '0;
      o_charge  <= 1'b0;
      o_ready   <= 1'b0;
      o_run     <= 1'b0;
      o_stop    <= 1'b0;
      o_disch   <= 1'b0;
      o_fault   <= 1'b0;
      o_cmd_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      frm_q     <= frm_d;
      trk_q     <= trk_d;
      phase_q   <= phase_d;
      o_charge  <= charge_d;
      o_ready   <= ready_d;
      o_run     <= run_d;
      o_stop    <= stop_d;
      o_disch   <= disch_d;
      o_fault   <= fault_d;
      o_cmd_err <= err_d;
    end

  assign o_phase = phase_q;

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    if (flt_s && state_q != FAULT) state_d = FAULT;
    else
      case (state_q)
        IDLE:    state_d = cmd5 ? CHARGE : armed ? DISCH : IDLE;
        CHARGE:  state_d = cmd6 ? STOP : expired ? READY : CHARGE;
        READY: begin
          if (sel && !stop_s) begin
            state_d = RUN;
            phase_d = cmd2_q[1:0] - 2'd1;
          end else state_d = cmd6 ? STOP : armed ? DISCH : READY;
        end
        RUN: begin
          if (stop_s || cmd6) state_d = STOP;
          else if (sel) phase_d = cmd2_q[1:0] - 2'd1;
        end
        STOP:    state_d = armed ? DISCH : (cmd5 && !stop_s) ? CHARGE : STOP;
        DISCH:   state_d = expired ? IDLE : DISCH;
        default: state_d = FAULT;
      endcase
    phase_d = (state_d == IDLE || state_d == DISCH || state_d == FAULT) ? 2'd0 : phase_d;
    t_d = (state_d == CHARGE && state_q != CHARGE) ? CLT :
          (state_d == DISCH && state_q != DISCH) ? DLT :
          (state_d == state_q && !expired) ? t_q - TW'(1) : '0;
  end

  always_comb begin
    charge_d = state_d == CHARGE;
    ready_d  = state_d == READY;
    run_d    = state_d == RUN;
    stop_d   = state_d == STOP;
    disch_d  = state_d == DISCH;
    fault_d  = state_d == FAULT;
    err_d    = err & (state_d != FAULT);
  end
endmodule

// File: tb/tb_cmd_sequencer.sv
// tb_cmd_sequencer: scoreboard bench walking the converter life-cycle,
// framing errors, discharge arming, fault latch and async reset.
module tb_cmd_sequencer;
  logic       clk = 1'b0, rst = 1'b1, i_strobe = 1'b0, i_stop_k = 1'b0, i_fault = 1'b0;
  logic [2:0] i_cmd = '0;
  logic       o_charge, o_ready, o_run, o_stop, o_disch, o_fault, o_cmd_err;
  logic [1:0] o_phase;

  cmd_sequencer #(.FREQ(1000), .CHARGE_US(20), .DISCH_US(10)) dut (
    .clk(clk), .rst(rst), .i_strobe(i_strobe), .i_cmd(i_cmd), .i_stop_k(i_stop_k), .i_fault(i_fault),
    .o_charge(o_charge), .o_ready(o_ready), .o_run(o_run), .o_phase(o_phase), .o_stop(o_stop),
    .o_disch(o_disch), .o_fault(o_fault), .o_cmd_err(o_cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_bad = 0;
  int chg_cyc = 0, dis_cyc = 0, err_cnt = 0, run_falls = 0;
  logic run_prev = 1'b0;

  always @(posedge clk) begin
    if (o_charge) chg_cyc <= chg_cyc + 1;
    if (o_disch) dis_cyc <= dis_cyc + 1;
    if (o_cmd_err) err_cnt <= err_cnt + 1;
    if (run_prev && !o_run) run_falls <= run_falls + 1;
    run_prev <= o_run;
  end

  function automatic logic [7:0] ev(input logic c, r, u, input logic [1:0] p, input logic s, d, f);
    return {c, r, u, p, s, d, f};
  endfunction

  function automatic logic [7:0] outs();
    return {o_charge, o_ready, o_run, o_phase, o_stop, o_disch, o_fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_pop();
    exp_t x;
    x = sb.pop_front();
    check(x.tag, {24'd0, outs()}, {24'd0, x.v});
  endtask

  task automatic send(input logic [2:0] c, input logic [7:0] e, input string tag);
    exp_t x;
    i_cmd = c;
    @(negedge clk);
    i_strobe = 1'b1;
    x.tag = tag;
    x.v = e;
    sb.push_back(x);
    repeat (3) @(negedge clk);
    sb_pop();
    i_strobe = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 100 && !o_ready; k++) @(negedge clk);
  endtask

  logic [7:0] e_idle, e_chg, e_rdy, e_flt;

  initial begin
    e_idle = '0;
    e_chg  = ev(1, 0, 0, 2'd0, 0, 0, 0);
    e_rdy  = ev(0, 1, 0, 2'd0, 0, 0, 0);
    e_flt  = ev(0, 0, 0, 2'd0, 0, 0, 1);
    repeat (3) @(negedge clk);
    check("rst_outs", {24'd0, outs()}, 32'd0);
    check("rst_err", {31'd0, o_cmd_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    send(3'd5, e_chg, "chg_on");
    send(3'd0, e_chg, "chg_sep");
    for (int k = 0; k < 100 && o_charge; k++) @(negedge clk);
    check("chg_len", chg_cyc, 32'd20);
    check("chg_ready", {24'd0, outs()}, {24'd0, e_rdy});

    for (int p = 0; p < 4; p++) begin
      send(3'(p + 1), ev(0, 0, 1, 2'(p), 0, 0, 0), "run_sel");
      send(3'd0, ev(0, 0, 1, 2'(p), 0, 0, 0), "run_sep");
    end
    check("run_gap", run_falls, 32'd0);

    @(negedge clk);
    i_stop_k = 1'b1;
    repeat (3) @(negedge clk);
    check("stop_key", {24'd0, outs()}, {24'd0, ev(0, 0, 0, 2'd3, 1, 0, 0)});
    send(3'd2, ev(0, 0, 0, 2'd3, 1, 0, 0), "stop_ign2");
    send(3'd0, ev(0, 0, 0, 2'd3, 1, 0, 0), "stop_sep");
    send(3'd3, ev(0, 0, 0, 2'd3, 1, 0, 0), "stop_ign3");
    send(3'd0, ev(0, 0, 0, 2'd3, 1, 0, 0), "stop_sep");
    check("stop_noerr", err_cnt, 32'd0);
    i_stop_k = 1'b0;

    send(3'd7, ev(0, 0, 0, 2'd3, 1, 0, 0), "arm7a");
    send(3'd0, ev(0, 0, 0, 2'd3, 1, 0, 0), "arm0a");
    send(3'd7, ev(0, 0, 0, 2'd3, 1, 0, 0), "arm7b");
    send(3'd0, ev(0, 0, 0, 2'd3, 1, 0, 0), "arm0b");
    send(3'd1, ev(0, 0, 0, 2'd0, 0, 1, 0), "disch_on");
    for (int k = 0; k < 100 && o_disch; k++) @(negedge clk);
    check("disch_len", dis_cyc, 32'd10);
    check("disch_idle", {24'd0, outs()}, {24'd0, e_idle});
    send(3'd0, e_idle, "bad_sep");
    send(3'd7, e_idle, "bad7");
    send(3'd0, e_idle, "bad0");
    send(3'd6, e_idle, "bad6");
    send(3'd0, e_idle, "bad0b");
    send(3'd1, e_idle, "bad1");
    check("bad_nodisch", dis_cyc, 32'd10);
    send(3'd0, e_idle, "bad_sep2");

    send(3'd5, e_chg, "chg2_on");
    send(3'd0, e_chg, "chg2_sep");
    wait_ready();
    i_stop_k = 1'b1;
    repeat (3) @(negedge clk);
    send(3'd1, e_rdy, "rdy_stopk");
    send(3'd0, e_rdy, "rdy_sep");
    i_stop_k = 1'b0;
    repeat (3) @(negedge clk);
    send(3'd1, ev(0, 0, 1, 2'd0, 0, 0, 0), "frm_first");
    send(3'd2, ev(0, 0, 1, 2'd0, 0, 0, 0), "frm_second");
    check("frm_err", err_cnt, 32'd1);
    send(3'd0, ev(0, 0, 1, 2'd0, 0, 0, 0), "frm_sep");
    send(3'd3, ev(0, 0, 1, 2'd2, 0, 0, 0), "frm_recover");
    check("frm_err_once", err_cnt, 32'd1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(3'd5, e_chg, "flt_chg");
    i_fault = 1'b1;
    repeat (3) @(negedge clk);
    check("flt_set", {24'd0, outs()}, {24'd0, e_flt});
    i_fault = 1'b0;
    send(3'd0, e_flt, "flt_sep");
    send(3'd5, e_flt, "flt_hold");

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(3'd5, e_chg, "chg3_on");
    send(3'd0, e_chg, "chg3_sep");
    wait_ready();
    check("chg3_ready", {24'd0, outs()}, {24'd0, e_rdy});
    send(3'd4, ev(0, 0, 1, 2'd3, 0, 0, 0), "run3");
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_run", {24'd0, outs()}, 32'd0);
    check("rst_run_err", {31'd0, o_cmd_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
